// File: rtl/alu_multicycle.sv
// Multicycle ALU: single-cycle logic/arith ops, WIDTH-cycle shift-add multiply,
// valid/ready handshake on both request and result sides.
module alu_multicycle #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] readdata1,
  input  logic [WIDTH-1:0] readdata2,
  input  logic [WIDTH-1:0] sign_extended,
  input  logic             alusrc,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_SLL = 3'd5;
  localparam logic [2:0] OP_SRL = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  logic [1:0]         state_q, state_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [SHW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d;
  logic               zero_q, zero_d;
  logic               carry_q, carry_d;
  logic               ovf_q, ovf_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;

  logic [WIDTH-1:0]   b_sel_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     diff_s;
  logic [WIDTH-1:0]   alu_res_s;
  logic               alu_c_s;
  logic               alu_v_s;
  logic [2*WIDTH-1:0] prod_step_s;

  assign b_sel_s     = alusrc ? sign_extended : readdata2;
  assign sum_s       = {1'b0, readdata1} + {1'b0, b_sel_s};
  assign diff_s      = {1'b0, readdata1} - {1'b0, b_sel_s};
  assign prod_step_s = acc_q + (mplier_q[0] ? mcand_q : {(2*WIDTH){1'b0}});

  // Single-cycle datapath for every op except MUL
  always_comb begin
    alu_res_s = {WIDTH{1'b0}};
    alu_c_s   = 1'b0;
    alu_v_s   = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_s = sum_s[WIDTH-1:0];
        alu_c_s   = sum_s[WIDTH];
        alu_v_s   = (readdata1[WIDTH-1] == b_sel_s[WIDTH-1]) &&
                    (sum_s[WIDTH-1] != readdata1[WIDTH-1]);
      end
      OP_SUB: begin
        // carry means "no borrow", i.e. A >= B unsigned
        alu_res_s = diff_s[WIDTH-1:0];
        alu_c_s   = ~diff_s[WIDTH];
        alu_v_s   = (readdata1[WIDTH-1] != b_sel_s[WIDTH-1]) &&
                    (diff_s[WIDTH-1] != readdata1[WIDTH-1]);
      end
      OP_AND:  alu_res_s = readdata1 & b_sel_s;
      OP_OR:   alu_res_s = readdata1 | b_sel_s;
      OP_XOR:  alu_res_s = readdata1 ^ b_sel_s;
      OP_SLL:  alu_res_s = readdata1 << b_sel_s[SHW-1:0];
      OP_SRL:  alu_res_s = readdata1 >> b_sel_s[SHW-1:0];
      default: alu_res_s = {WIDTH{1'b0}};
    endcase
  end

  // Control FSM and multiplier iteration
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    out_d    = out_q;
    zero_d   = zero_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          if (op == OP_MUL) begin
            state_d  = S_MUL;
            acc_d    = {(2*WIDTH){1'b0}};
            mcand_d  = {{WIDTH{1'b0}}, readdata1};
            mplier_d = b_sel_s;
            cnt_d    = {SHW{1'b0}};
          end else begin
            state_d = S_DONE;
            out_d   = alu_res_s;
            zero_d  = (alu_res_s == {WIDTH{1'b0}});
            carry_d = alu_c_s;
            ovf_d   = alu_v_s;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        // Fixed WIDTH iterations regardless of operand values
        acc_d    = prod_step_s;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + {{(SHW-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          out_d   = prod_step_s[WIDTH-1:0];
          zero_d  = (prod_step_s[WIDTH-1:0] == {WIDTH{1'b0}});
          carry_d = |prod_step_s[2*WIDTH-1:WIDTH];
          ovf_d   = 1'b0;
        end else begin
          state_d = S_MUL;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign in_ready_d  = (state_d == S_IDLE);
  assign out_valid_d = (state_d == S_DONE);
  assign busy_d      = (state_d != S_IDLE);

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      acc_q       <= {(2*WIDTH){1'b0}};
      mcand_q     <= {(2*WIDTH){1'b0}};
      mplier_q    <= {WIDTH{1'b0}};
      cnt_q       <= {SHW{1'b0}};
      out_q       <= {WIDTH{1'b0}};
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      out_q       <= out_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out       = out_q;
  assign zero      = zero_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;

endmodule
